// File: rtl/cronometro_control.sv
// ---------------------------------------------------------------------------
// cronometro_control
//
// Front-panel controller for the contador_final stopwatch counter.
// Takes two raw push-buttons (start/stop and lap/clear), synchronises and
// debounces them, runs the IDLE/RUN/LAP/STOP state machine, drives the
// counter's Enable and Nreset inputs, and selects what the 7-segment driver
// shows: either the live count or a lap value frozen when the lap was taken.
// Every register updates on the falling edge of NEclk, the same edge the
// counter uses, so the whole front panel stays in one clock domain.
//
// Parameters
//   DEBOUNCE  cycles a synchronised button level must hold before it is
//             accepted (>= 1)
//   LAP_MAX   saturation value of lap_count (<= 15)
//
// Ports
//   NEclk       in   1   clock, falling-edge active
//   Nreset      in   1   asynchronous reset, active low
//   btn_ss      in   1   raw start/stop button, active high, asynchronous
//   btn_lr      in   1   raw lap/clear button, active high, asynchronous
//   live_bcd    in  36   counter digits {h1,h0,min1,min0,s1,s0,ms2,ms1,ms0}
//   cnt_enable  out  1   counter Enable
//   cnt_nreset  out  1   counter Nreset (active low)
//   disp_bcd    out 36   digits for the display, same packing as live_bcd
//   lap_active  out  1   high while disp_bcd shows a frozen lap value
//   lap_count   out  4   laps taken since the last clear, saturating
//   state       out  2   IDLE=0, RUN=1, LAP=2, STOP=3
// ---------------------------------------------------------------------------
module cronometro_control #(
    parameter int DEBOUNCE = 20,
    parameter int LAP_MAX  = 9
) (
    input  logic        NEclk,
    input  logic        Nreset,
    input  logic        btn_ss,
    input  logic        btn_lr,
    input  logic [35:0] live_bcd,
    output logic        cnt_enable,
    output logic        cnt_nreset,
    output logic [35:0] disp_bcd,
    output logic        lap_active,
    output logic [3:0]  lap_count,
    output logic [1:0]  state
);

    // -----------------------------------------------------------------------
    // Debounce counter sizing. The counter never needs to hold DEBOUNCE
    // itself: the edge on which it would get there is the edge on which the
    // level is accepted and the counter clears instead.
    // -----------------------------------------------------------------------
    localparam int                CNT_W    = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]        LAP_SAT  = 4'(LAP_MAX);

    // Button index 0 = start/stop, index 1 = lap/clear.
    localparam int BTN_SS = 0;
    localparam int BTN_LR = 1;

    logic [1:0] btn_raw;
    logic [1:0] press_pulse;

    assign btn_raw = {btn_lr, btn_ss};

    // -----------------------------------------------------------------------
    // Per-button synchroniser and debouncer.
    //   sync1_reg/sync2_reg : two-flop synchroniser for the asynchronous pin
    //   level_reg           : the accepted (debounced) level
    //   cnt_reg             : consecutive cycles sync2 has disagreed with the
    //                         accepted level
    //   pulse_reg           : one-cycle press strobe, raised only when the
    //                         accepted level flips 0->1; releases are
    //                         debounced the same way but never strobe
    // With the raw pin stable from edge 0, sync2 is high after edge 1, the
    // counter counts on edges 2..DEBOUNCE, and the flip plus strobe land on
    // edge DEBOUNCE+1. The FSM therefore acts on edge DEBOUNCE+2.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic             pulse_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(negedge NEclk or negedge Nreset) begin
                if (!Nreset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    pulse_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    pulse_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        // Any agreement restarts qualification, so a glitch
                        // shorter than DEBOUNCE cycles never gets accepted.
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                        pulse_reg <= sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
            end

            assign press_pulse[gi] = pulse_reg;
        end
    endgenerate

    logic ss_press;
    logic lr_press;

    assign ss_press = press_pulse[BTN_SS];
    assign lr_press = press_pulse[BTN_LR];

    // -----------------------------------------------------------------------
    // Control state machine
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  lap_count_reg;
    logic [3:0]  lap_count_next;
    logic [35:0] lap_reg;
    logic [35:0] lap_next;

    always_ff @(negedge NEclk or negedge Nreset) begin
        if (!Nreset) begin
            state_reg     <= ST_IDLE;
            lap_count_reg <= 4'd0;
            lap_reg       <= 36'd0;
        end else begin
            state_reg     <= state_next;
            lap_count_reg <= lap_count_next;
            lap_reg       <= lap_next;
        end
    end

    // Start/stop is checked first in every state, so when both strobes
    // arrive on the same cycle the lap/clear request is simply dropped.
    always_comb begin
        state_next     = state_reg;
        lap_count_next = lap_count_reg;
        lap_next       = lap_reg;

        case (state_reg)
            ST_IDLE: begin
                if (ss_press) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (ss_press) begin
                    state_next = ST_STOP;
                end else if (lr_press) begin
                    state_next = ST_LAP;
                    lap_next   = live_bcd;
                    if (lap_count_reg < LAP_SAT) begin
                        lap_count_next = lap_count_reg + 4'd1;
                    end
                end
            end

            ST_LAP: begin
                if (ss_press) begin
                    state_next = ST_STOP;
                end else if (lr_press) begin
                    state_next = ST_RUN;
                end
            end

            ST_STOP: begin
                if (ss_press) begin
                    state_next = ST_RUN;
                end else if (lr_press) begin
                    // lap_reg is left alone: it is only visible in LAP and
                    // will be overwritten by the next lap capture.
                    state_next     = ST_IDLE;
                    lap_count_next = 4'd0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Moore output decode. Because it depends only on registers, the reset
    // values appear the moment Nreset falls, and no button path reaches an
    // output combinationally.
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_enable = 1'b0;
        cnt_nreset = 1'b1;
        lap_active = 1'b0;
        disp_bcd   = live_bcd;

        case (state_reg)
            ST_IDLE: begin
                cnt_nreset = 1'b0;
            end
            ST_RUN: begin
                cnt_enable = 1'b1;
            end
            ST_LAP: begin
                cnt_enable = 1'b1;
                lap_active = 1'b1;
                disp_bcd   = lap_reg;
            end
            ST_STOP: begin
                cnt_enable = 1'b0;
            end
            default: begin
                cnt_nreset = 1'b0;
            end
        endcase
    end

    assign lap_count = lap_count_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_cronometro_control.sv
// ---------------------------------------------------------------------------
// tb_cronometro_control
//
// Directed bench for cronometro_control with DEBOUNCE=4 and LAP_MAX=9.
// Inputs change and outputs are sampled on the rising edge of NEclk, half a
// period away from the falling edge the design runs on. Expected output sets
// come from a small behavioural model of the controller and are queued when
// a stimulus step is driven, then popped and compared when the design has
// had the cycles it needs to respond.
// ---------------------------------------------------------------------------
module tb_cronometro_control;

    localparam int DEBOUNCE = 4;
    localparam int LAP_MAX  = 9;
    // Edges from the first raw sample to the FSM transition.
    localparam int ACT_EDGE = DEBOUNCE + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LAP  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic        NEclk;
    logic        Nreset;
    logic        btn_ss;
    logic        btn_lr;
    logic [35:0] live_bcd;
    logic        cnt_enable;
    logic        cnt_nreset;
    logic [35:0] disp_bcd;
    logic        lap_active;
    logic [3:0]  lap_count;
    logic [1:0]  state;

    cronometro_control #(
        .DEBOUNCE (DEBOUNCE),
        .LAP_MAX  (LAP_MAX)
    ) dut (
        .NEclk      (NEclk),
        .Nreset     (Nreset),
        .btn_ss     (btn_ss),
        .btn_lr     (btn_lr),
        .live_bcd   (live_bcd),
        .cnt_enable (cnt_enable),
        .cnt_nreset (cnt_nreset),
        .disp_bcd   (disp_bcd),
        .lap_active (lap_active),
        .lap_count  (lap_count),
        .state      (state)
    );

    initial begin
        NEclk = 1'b1;
        forever #5 NEclk = ~NEclk;
    end

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        en;
        logic        nr;
        logic        la;
        logic [3:0]  lc;
        logic [35:0] disp;
    } exp_t;

    exp_t sb[$];

    // Behavioural model of the controller
    logic [1:0]  m_state;
    logic [3:0]  m_lc;
    logic [35:0] m_lap;

    function automatic exp_t model_out(input string tag);
        exp_t e;
        e.tag  = tag;
        e.st   = m_state;
        e.en   = (m_state == S_RUN) || (m_state == S_LAP);
        e.nr   = (m_state != S_IDLE);
        e.la   = (m_state == S_LAP);
        e.lc   = m_lc;
        e.disp = (m_state == S_LAP) ? m_lap : live_bcd;
        return e;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_lc    = 4'd0;
        m_lap   = 36'd0;
    endtask

    task automatic model_step(input logic ss, input logic lr);
        case (m_state)
            S_IDLE: if (ss) m_state = S_RUN;
            S_RUN: begin
                if (ss) m_state = S_STOP;
                else if (lr) begin
                    m_state = S_LAP;
                    m_lap   = live_bcd;
                    if (m_lc < 4'(LAP_MAX)) m_lc = m_lc + 4'd1;
                end
            end
            S_LAP: begin
                if (ss) m_state = S_STOP;
                else if (lr) m_state = S_RUN;
            end
            default: begin
                if (ss) m_state = S_RUN;
                else if (lr) begin
                    m_state = S_IDLE;
                    m_lc    = 4'd0;
                end
            end
        endcase
    endtask

    task automatic cmp(input string tag, input logic [35:0] obs, input logic [35:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL scoreboard_underflow observed=%0d expected=1", sb.size());
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".state"},      36'(state),      36'(e.st));
        cmp({e.tag, ".cnt_enable"}, 36'(cnt_enable), 36'(e.en));
        cmp({e.tag, ".cnt_nreset"}, 36'(cnt_nreset), 36'(e.nr));
        cmp({e.tag, ".lap_active"}, 36'(lap_active), 36'(e.la));
        cmp({e.tag, ".lap_count"},  36'(lap_count),  36'(e.lc));
        cmp({e.tag, ".disp_bcd"},   disp_bcd,        e.disp);
        $display("step %-14s state=%0d en=%b nr=%b lap=%b cnt=%0d disp=%h",
                 e.tag, state, cnt_enable, cnt_nreset, lap_active, lap_count, disp_bcd);
    endtask

    // Queue the present model outputs and compare them on the next rising edge.
    task automatic check_steady(input string tag);
        sb.push_back(model_out(tag));
        @(posedge NEclk);
        check_pop();
    endtask

    // Hold the selected buttons from the next rising edge. The first falling
    // edge after that is edge 0: the design must still show the old state
    // after edge ACT_EDGE-1 and the new state after edge ACT_EDGE. The
    // buttons are then released and left long enough to re-qualify low.
    task automatic press(input logic ss, input logic lr, input bit rel_rst, input string tag);
        @(posedge NEclk);
        btn_ss = ss;
        btn_lr = lr;
        if (rel_rst) Nreset = 1'b1;
        sb.push_back(model_out({tag, "_hold"}));
        model_step(ss, lr);
        sb.push_back(model_out(tag));
        repeat (ACT_EDGE) @(posedge NEclk);
        check_pop();
        @(posedge NEclk);
        check_pop();
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        repeat (DEBOUNCE + 6) @(posedge NEclk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        Nreset   = 1'b0;
        btn_ss   = 1'b0;
        btn_lr   = 1'b0;
        live_bcd = 36'h123456789;
        model_reset();

        // Power-on reset: counter held cleared, display follows live input.
        repeat (3) @(posedge NEclk);
        check_steady("reset");
        Nreset = 1'b1;
        live_bcd = 36'h000000000;
        repeat (2) @(posedge NEclk);
        check_steady("after_reset");

        // Glitch of three cycles must not start the watch.
        @(posedge NEclk);
        btn_ss = 1'b1;
        repeat (3) @(posedge NEclk);
        btn_ss = 1'b0;
        repeat (12) @(posedge NEclk);
        check_steady("glitch_ss");

        // Lap/clear is ignored in IDLE.
        press(1'b0, 1'b1, 1'b0, "idle_lr");

        // Qualified start press.
        press(1'b1, 1'b0, 1'b0, "start");

        // Lap capture freezes the display while the live count moves on.
        @(posedge NEclk);
        live_bcd = 36'h000001250;
        press(1'b0, 1'b1, 1'b0, "lap1");
        @(posedge NEclk);
        live_bcd = 36'h000001251;
        check_steady("lap1_frozen");
        live_bcd = 36'h000001317;
        press(1'b0, 1'b1, 1'b0, "lap1_exit");

        // Asynchronous reset mid-RUN, with start/stop held through reset.
        @(posedge NEclk);
        #2;
        Nreset = 1'b0;
        btn_ss = 1'b1;
        model_reset();
        #1;
        sb.push_back(model_out("mid_reset"));
        check_pop();
        repeat (4) @(posedge NEclk);
        press(1'b1, 1'b0, 1'b1, "requal_start");

        // Stop, resume, stop, clear.
        live_bcd = 36'h000000420;
        press(1'b1, 1'b0, 1'b0, "stop");
        press(1'b1, 1'b0, 1'b0, "resume");
        live_bcd = 36'h000000555;
        press(1'b1, 1'b0, 1'b0, "stop2");
        press(1'b0, 1'b1, 1'b0, "clear");
        live_bcd = 36'h000000000;
        press(1'b0, 1'b1, 1'b0, "idle_lr2");

        // Lap counter saturation over eleven lap round trips.
        press(1'b1, 1'b0, 1'b0, "start_sat");
        for (int i = 0; i < 11; i++) begin
            live_bcd = 36'h000002000 + 36'(i);
            press(1'b0, 1'b1, 1'b0, $sformatf("sat_lap%0d", i + 1));
            press(1'b0, 1'b1, 1'b0, $sformatf("sat_run%0d", i + 1));
        end

        // Simultaneous presses: start/stop wins in RUN and in LAP.
        press(1'b1, 1'b0, 1'b0, "stop_sat");
        press(1'b0, 1'b1, 1'b0, "clear_sat");
        press(1'b1, 1'b0, 1'b0, "start_sim");
        live_bcd = 36'h000010101;
        press(1'b0, 1'b1, 1'b0, "lap_sim");
        press(1'b0, 1'b1, 1'b0, "run_sim");
        live_bcd = 36'h000020202;
        press(1'b1, 1'b1, 1'b0, "both_in_run");
        press(1'b1, 1'b0, 1'b0, "resume_sim");
        live_bcd = 36'h000030303;
        press(1'b0, 1'b1, 1'b0, "lap_sim2");
        live_bcd = 36'h000040404;
        press(1'b1, 1'b1, 1'b0, "both_in_lap");

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
